// File: rtl/nbj_redirect_unit.sv
// Non-branch-jump redirect unit: queues front-end jump predictions, checks them in order
// against resolved targets, and issues a one-cycle correction plus flush on a mismatch.
// Optional statistics counters are enabled by defining NBJ_REDIRECT_STATS_EN.
module nbj_redirect_unit #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_pushValid,
    output logic             o_pushReady,
    input  logic [31:0]      i_pushPredPc_32,
    input  logic [2:0]       i_pushType_3,
    input  logic [2:0]       i_pushBtbIndex_3,
    input  logic             i_resolveValid,
    input  logic [31:0]      i_resolveTarget_32,
    output logic [31:0]      o_correctPc_32,
    output logic [2:0]       o_correctPcIndex_3,
    output logic             o_type,
`ifdef NBJ_REDIRECT_STATS_EN
    output logic [15:0]      o_resolveCount_16,
    output logic [15:0]      o_mispredictCount_16,
`endif
    output logic [PTR_W:0]   o_count_4,
    output logic             o_badTarget,
    output logic             o_underflow
);

    localparam logic [2:0] TYPE_JALR = 3'd3;

    // Entry layout: {pred_pc[31:0], type[2:0], btb_index[2:0]}
    logic [37:0]       mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    count;
    logic [PTR_W:0]    count_next;
    logic              redirect_q;

    logic [37:0]       head;
    logic [31:0]       head_pc;
    logic [2:0]        head_type;
    logic [2:0]        head_idx;
    logic              push_ready;
    logic              push_fire;
    logic              resolve_ok;
    logic              resolve_ignored;
    logic              mismatch;
    logic              pop;

    assign head      = mem[rd_ptr];
    assign head_pc   = head[37:6];
    assign head_type = head[5:3];
    assign head_idx  = head[2:0];

    // Push side: valid/ready handshake, a transfer happens when both are high on an edge.
    // A resolve never frees a slot for a push in the same cycle.
    always_comb begin
        push_ready      = (count != (PTR_W+1)'(DEPTH)) && !redirect_q;
        push_fire       = i_pushValid && push_ready;
        resolve_ok      = i_resolveValid && (count != '0) && !redirect_q;
        resolve_ignored = i_resolveValid && !resolve_ok;
        mismatch        = resolve_ok && (head_pc != i_resolveTarget_32);
        pop             = resolve_ok && !mismatch;
    end

    always_comb begin
        count_next = count;
        case ({push_fire, pop})
            2'b10:   count_next = count + (PTR_W+1)'(1);
            2'b01:   count_next = count - (PTR_W+1)'(1);
            default: count_next = count;
        endcase
    end

    assign o_pushReady = push_ready;
    assign o_count_4   = count;

    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr] <= {i_pushPredPc_32, i_pushType_3, i_pushBtbIndex_3};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            redirect_q <= 1'b0;
        end else if (mismatch) begin
            // Flush drops everything, including an entry pushed in this same cycle.
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            redirect_q <= 1'b1;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)       rd_ptr <= rd_ptr + PTR_W'(1);
            count      <= count_next;
            redirect_q <= 1'b0;
        end
    end

    // A zero target cannot be signalled (zero means "no correction"), so nothing is driven.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_correctPc_32     <= '0;
            o_correctPcIndex_3 <= '0;
            o_type             <= 1'b0;
        end else if (mismatch && (i_resolveTarget_32 != '0)) begin
            o_correctPc_32     <= i_resolveTarget_32;
            o_correctPcIndex_3 <= head_idx;
            o_type             <= (head_type != TYPE_JALR);
        end else begin
            o_correctPc_32     <= '0;
            o_correctPcIndex_3 <= '0;
            o_type             <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_badTarget <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (mismatch && (i_resolveTarget_32 == '0)) o_badTarget <= 1'b1;
            if (resolve_ignored)                         o_underflow <= 1'b1;
        end
    end

`ifdef NBJ_REDIRECT_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_resolveCount_16    <= '0;
            o_mispredictCount_16 <= '0;
        end else begin
            if (resolve_ok && (o_resolveCount_16 != 16'hFFFF))
                o_resolveCount_16 <= o_resolveCount_16 + 16'd1;
            if (mismatch && (o_mispredictCount_16 != 16'hFFFF))
                o_mispredictCount_16 <= o_mispredictCount_16 + 16'd1;
        end
    end
`endif

endmodule
